// File: rtl/fetch_exec_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit processor: owns the PC and the IR write enable.
// Optional ack-timeout watchdog enabled by defining CTRL_ACK_TIMEOUT_EN.
module fetch_exec_ctrl #(
  parameter int unsigned PC_W           = 16,
  parameter int unsigned RESET_PC       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [15:0]     ir_i,
  input  logic            zero_i,
  output logic            imem_req_o,
  input  logic            imem_ack_i,
  output logic [PC_W-1:0] pc_o,
  output logic            ir_we_o,
  output logic [1:0]      alu_op_o,
  output logic            rf_we_o,
  output logic            rf_src_mem_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  input  logic            dmem_ack_i,
  output logic            busy_o,
  output logic            halted_o,
  output logic            illegal_o,
  output logic            err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_ERR
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_LOAD  = 4'h5;
  localparam logic [3:0] OP_STORE = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [3:0]        opcode_c;
  logic [PC_W-1:0]   jump_pc_c;

  assign opcode_c  = ir_i[15:12];
  assign jump_pc_c = PC_W'(ir_i[11:0]);
  assign pc_o      = pc_q;
  assign alu_op_o  = alu_op_q;

`ifdef CTRL_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // State and datapath-control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_W'(RESET_PC);
      alu_op_q <= 2'd0;
`ifdef CTRL_ACK_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      alu_op_q <= alu_op_d;
`ifdef CTRL_ACK_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    alu_op_d     = alu_op_q;
    imem_req_o   = 1'b0;
    ir_we_o      = 1'b0;
    rf_we_o      = 1'b0;
    rf_src_mem_o = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    busy_o       = 1'b0;
    halted_o     = 1'b0;
    illegal_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy_o     = 1'b1;
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        busy_o  = 1'b1;
        state_d = S_FETCH;
        if (opcode_c != OP_NOP && opcode_c <= OP_OR) begin
          // ADD..OR occupy opcodes 1..4; the ALU wants them as 0..3
          alu_op_d = 2'(opcode_c - 4'd1);
          state_d  = S_EXEC;
        end else if (opcode_c == OP_LOAD || opcode_c == OP_STORE) begin
          state_d = S_MEM;
        end else if (opcode_c == OP_JMP || (opcode_c == OP_JZ && zero_i)) begin
          pc_d = jump_pc_c;
        end else if (opcode_c == OP_HALT) begin
          state_d = S_HALT;
        end else if (opcode_c > OP_JZ) begin
          illegal_o = 1'b1;
        end
      end
      S_EXEC: begin
        busy_o  = 1'b1;
        rf_we_o = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM: begin
        busy_o     = 1'b1;
        dmem_req_o = 1'b1;
        dmem_we_o  = (opcode_c == OP_STORE);
        if (dmem_ack_i) begin
          rf_we_o      = (opcode_c == OP_LOAD);
          rf_src_mem_o = (opcode_c == OP_LOAD);
          state_d      = S_FETCH;
        end
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      S_ERR: begin
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CTRL_ACK_TIMEOUT_EN
    // Count consecutive unacknowledged request cycles; trip into ERR at the limit
    cnt_d = '0;
    err_d = err_q;
    if ((state_q == S_FETCH && !imem_ack_i) || (state_q == S_MEM && !dmem_ack_i)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = S_ERR;
      end
    end
`endif
  end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Self-checking bench for fetch_exec_ctrl: directed plan steps plus random instruction streams
// checked cycle by cycle against a per-instruction reference model.
module tb_fetch_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst, start_i, zero_i, imem_ack_i, dmem_ack_i;
  logic [15:0] ir_i;
  logic        imem_req_o, ir_we_o, rf_we_o, rf_src_mem_o, dmem_req_o, dmem_we_o;
  logic        busy_o, halted_o, illegal_o, err_o;
  logic [15:0] pc_o;
  logic [1:0]  alu_op_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_pc;
  logic [1:0]  exp_alu;

  always #5 clk = ~clk;

  fetch_exec_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ir_i(ir_i), .zero_i(zero_i),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .pc_o(pc_o), .ir_we_o(ir_we_o),
    .alu_op_o(alu_op_o), .rf_we_o(rf_we_o), .rf_src_mem_o(rf_src_mem_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .busy_o(busy_o), .halted_o(halted_o), .illegal_o(illegal_o), .err_o(err_o)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_imem_req"}, imem_req_o, 1'b0);
    chk1({tag, "_dmem_req"}, dmem_req_o, 1'b0);
    chk1({tag, "_ir_we"}, ir_we_o, 1'b0);
    chk1({tag, "_rf_we"}, rf_we_o, 1'b0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    #1 chk1("idle_busy", busy_o, 1'b0);
    tick();
    start_i = 1'b0;
  endtask

  // One instruction from its first FETCH cycle until the controller is back in FETCH (or HALT)
  task automatic run_instr(input logic [15:0] instr, input logic z, input int iw, input int dw);
    logic [3:0] op;
    op = instr[15:12];
    for (int k = 0; k <= iw; k++) begin
      imem_ack_i = (k == iw);
      dmem_ack_i = 1'($urandom);
      #1;
      chk1("fetch_imem_req", imem_req_o, 1'b1);
      chk1("fetch_dmem_req", dmem_req_o, 1'b0);
      chk1("fetch_ir_we", ir_we_o, k == iw);
      chk1("fetch_rf_we", rf_we_o, 1'b0);
      chk1("fetch_busy", busy_o, 1'b1);
      chk1("fetch_err", err_o, 1'b0);
      chk16("fetch_pc", pc_o, exp_pc);
      tick();
    end
    ir_i   = instr;
    exp_pc = exp_pc + 16'd1;

    zero_i     = z;
    imem_ack_i = 1'($urandom);
    dmem_ack_i = 1'($urandom);
    #1;
    chk1("dec_illegal", illegal_o, op >= 4'h9 && op <= 4'hE);
    chk1("dec_ir_we", ir_we_o, 1'b0);
    chk1("dec_rf_we", rf_we_o, 1'b0);
    chk1("dec_imem_req", imem_req_o, 1'b0);
    chk1("dec_dmem_req", dmem_req_o, 1'b0);
    chk16("dec_pc", pc_o, exp_pc);
    tick();
    if (op == 4'h7 || (op == 4'h8 && z)) exp_pc = {4'h0, instr[11:0]};

    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: begin
        case (op)
          4'h1: exp_alu = 2'd0;
          4'h2: exp_alu = 2'd1;
          4'h3: exp_alu = 2'd2;
          default: exp_alu = 2'd3;
        endcase
        imem_ack_i = 1'($urandom);
        dmem_ack_i = 1'($urandom);
        #1;
        chk1("exec_rf_we", rf_we_o, 1'b1);
        chk1("exec_rf_src_mem", rf_src_mem_o, 1'b0);
        chk16("exec_alu_op", 16'(alu_op_o), 16'(exp_alu));
        chk1("exec_imem_req", imem_req_o, 1'b0);
        chk1("exec_ir_we", ir_we_o, 1'b0);
        tick();
      end
      4'h5, 4'h6: begin
        for (int k = 0; k <= dw; k++) begin
          dmem_ack_i = (k == dw);
          imem_ack_i = 1'($urandom);
          #1;
          chk1("mem_dmem_req", dmem_req_o, 1'b1);
          chk1("mem_imem_req", imem_req_o, 1'b0);
          chk1("mem_dmem_we", dmem_we_o, op == 4'h6);
          chk1("mem_rf_we", rf_we_o, op == 4'h5 && k == dw);
          chk1("mem_rf_src_mem", rf_src_mem_o, op == 4'h5 && k == dw);
          chk1("mem_ir_we", ir_we_o, 1'b0);
          chk16("mem_alu_op_hold", 16'(alu_op_o), 16'(exp_alu));
          tick();
        end
      end
      4'hF: begin
        for (int k = 0; k < 4; k++) begin
          start_i    = (k != 0);
          imem_ack_i = 1'($urandom);
          #1;
          chk1("halt_halted", halted_o, 1'b1);
          chk_quiet("halt");
          tick();
        end
        start_i = 1'b0;
      end
      default: ;
    endcase
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; zero_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
    ir_i = 16'h0000;
    exp_pc = 16'h0000; exp_alu = 2'd0;
    @(negedge clk);
    tick();
    #1;
    chk16("rst_pc", pc_o, 16'h0000);
    chk16("rst_alu_op", 16'(alu_op_o), 16'h0000);
    chk_quiet("rst");
    chk1("rst_halted", halted_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_rf_src_mem", rf_src_mem_o, 1'b0);
    rst = 1'b0;
    tick();
    #1 chk_quiet("idle");
    do_start();

    // Directed plan
    run_instr(16'h1123, 1'b0, 0, 0);
    chk16("add_pc", pc_o, 16'h0001);
    run_instr(16'h5234, 1'b0, 0, 2);
    run_instr(16'h7ABC, 1'b0, 1, 0);
    run_instr(16'h8010, 1'b0, 0, 0);
    run_instr(16'h8055, 1'b1, 2, 0);
    run_instr(16'hB123, 1'b0, 0, 0);
    run_instr(16'h0000, 1'b1, 0, 0);
    run_instr(16'h6000, 1'b0, 0, 1);
    run_instr(16'h2000, 1'b0, 0, 0);
    run_instr(16'h3000, 1'b0, 0, 0);
    run_instr(16'h4000, 1'b0, 0, 0);

    // Random instruction stream (HALT excluded so the stream keeps running)
    for (int n = 0; n < 150; n++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(ins, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    run_instr(16'hF000, 1'b0, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = 16'h0000;
    #1;
    chk1("halt_rst_halted", halted_o, 1'b0);
    chk16("halt_rst_pc", pc_o, 16'h0000);

    // Reset during a MEM wait drops the request and discards the pending ack
    do_start();
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    ir_i = 16'h5234;
    tick();
    #1 chk1("memwait_dmem_req", dmem_req_o, 1'b1);
    tick();
    rst = 1'b1;
    dmem_ack_i = 1'b1;
    tick();
    rst = 1'b0;
    dmem_ack_i = 1'b0;
    #1;
    chk16("memrst_pc", pc_o, 16'h0000);
    chk1("memrst_rf_src_mem", rf_src_mem_o, 1'b0);
    chk_quiet("memrst");
    tick();
    #1 chk_quiet("memrst_idle");

    // Reset wins over a simultaneous start
    rst = 1'b1;
    start_i = 1'b1;
    tick();
    rst = 1'b0;
    start_i = 1'b0;
    #1 chk_quiet("rst_start");
    tick();
    #1 chk_quiet("rst_start_idle");

    // Instruction memory that never acknowledges
    do_start();
`ifdef CTRL_ACK_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      #1;
      chk1("to_imem_req", imem_req_o, 1'b1);
      chk1("to_err_low", err_o, 1'b0);
      tick();
    end
    #1;
    chk1("to_err", err_o, 1'b1);
    chk_quiet("to_err");
    tick();
    #1 chk1("to_err_sticky", err_o, 1'b1);
`else
    for (int k = 0; k < 40; k++) begin
      #1;
      chk1("noack_imem_req", imem_req_o, 1'b1);
      chk1("noack_err", err_o, 1'b0);
      tick();
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk1("final_err", err_o, 1'b0);
    chk_quiet("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
